// File: rtl/mem_responder.sv
// Word-addressed memory responder: services Read/Write strobes with fixed,
// parameterised latencies and a one-cycle MemReady pulse; side-band preload port.
module mem_responder #(
  parameter int ADDR_WIDTH    = 9,
  parameter int DATA_WIDTH    = 32,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic [DATA_WIDTH-1:0] Mdatain,
  output logic                  MemReady,
  output logic                  Busy,
  input  logic                  LoadEn,
  input  logic [ADDR_WIDTH-1:0] LoadAddr,
  input  logic [DATA_WIDTH-1:0] LoadData
);

  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam int DEPTH   = 2 ** ADDR_WIDTH;

  localparam logic [CNT_W-1:0] RD_LAT  = CNT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0] WR_LAT  = CNT_W'(WRITE_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    cap_addr, cap_data;
  logic                    rd_done, wr_done, load_we;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign Busy = (state_q != IDLE);

  // Next-state and control decode; Read wins over Write when both are high.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_addr = 1'b0;
    cap_data = 1'b0;
    rd_done  = 1'b0;
    wr_done  = 1'b0;
    load_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Read) begin
          state_d  = RD_WAIT;
          cnt_d    = CNT_ONE;
          cap_addr = 1'b1;
        end else if (Write) begin
          state_d  = WR_WAIT;
          cnt_d    = CNT_ONE;
          cap_addr = 1'b1;
          cap_data = 1'b1;
        end else if (LoadEn) begin
          load_we = 1'b1;
        end
      end
      RD_WAIT: begin
        if (cnt_q == RD_LAT) begin
          rd_done = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WR_WAIT: begin
        if (cnt_q == WR_LAT) begin
          wr_done = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      Mdatain  <= '0;
      MemReady <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      MemReady <= rd_done | wr_done;
      if (rd_done) begin
        Mdatain <= mem[addr_q];
      end
    end
  end

  // Request capture and array; an aborted write never commits because reset
  // forces the state back to IDLE before the completing edge.
  always_ff @(posedge Clock) begin
    if (cap_addr) begin
      addr_q <= Address;
    end
    if (cap_data) begin
      data_q <= DataIn;
    end
    if (wr_done) begin
      mem[addr_q] <= data_q;
    end else if (load_we) begin
      mem[LoadAddr] <= LoadData;
    end
  end

endmodule
